// File: rtl/multicycle_processor_top.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB over one shared req/ready memory port, traps into HALT.
// Optional cycle/instret counters are enabled with `define MCP_PERF_COUNTERS_EN.
module multicycle_processor_top #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              retire,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out
`ifdef MCP_PERF_COUNTERS_EN
  ,
  output logic [31:0]       cycle_count,
  output logic [31:0]       instret_count
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] F_ADD    = 6'h20;
  localparam logic [5:0] F_SUB    = 6'h22;
  localparam logic [5:0] F_AND    = 6'h24;
  localparam logic [5:0] F_OR     = 6'h25;
  localparam logic [5:0] F_SLT    = 6'h2A;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       ir_q, a_q, b_q, alu_q, mdr_q;
  logic [31:0]       rf_q [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, wb_idx;
  logic [31:0] imm_sext, addr_sum, alu_r, pc_ext, jump_tgt, wb_dat;
  logic        legal;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign addr_sum = a_q + imm_sext;
  assign pc_ext   = 32'(pc_q);
  assign jump_tgt = {pc_ext[31:28], ir_q[25:0], 2'b00};
  assign wb_idx   = (opcode == OP_RTYPE) ? rd : rt;
  assign wb_dat   = (opcode == OP_LW) ? mdr_q : alu_q;

  always_comb begin
    alu_r = '0;
    case (funct)
      F_ADD:   alu_r = a_q + b_q;
      F_SUB:   alu_r = a_q - b_q;
      F_AND:   alu_r = a_q & b_q;
      F_OR:    alu_r = a_q | b_q;
      F_SLT:   alu_r = {31'b0, $signed(a_q) < $signed(b_q)};
      default: alu_r = '0;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_RTYPE:                           legal = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
      OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
  end

  // Port controls come straight from state and are masked by rst so an access aborts in the reset cycle.
  assign mem_req   = !rst && (state_q == S_FETCH || state_q == S_MEM);
  assign mem_we    = !rst && (state_q == S_MEM) && (opcode == OP_SW);
  assign mem_addr  = (state_q == S_MEM) ? alu_q[ADDR_W-1:0] : pc_q;
  assign mem_wdata = b_q;
  assign retire    = !rst && ((state_q == S_WB)
                     || (state_q == S_EXEC && (opcode == OP_BEQ || opcode == OP_J))
                     || (state_q == S_MEM && opcode == OP_SW && mem_ready));
  assign halted    = !rst && (state_q == S_HALT);
  assign pc_out    = pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_VECTOR;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH: if (mem_ready) begin
          ir_q    <= mem_rdata;
          pc_q    <= pc_q + ADDR_W'(4);
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          a_q     <= rf_q[rs];
          b_q     <= rf_q[rt];
          alu_q   <= pc_ext + (imm_sext << 2);
          state_q <= legal ? S_EXEC : S_HALT;
        end
        S_EXEC: begin
          case (opcode)
            OP_RTYPE: begin alu_q <= alu_r;    state_q <= S_WB; end
            OP_ADDI:  begin alu_q <= addr_sum; state_q <= S_WB; end
            OP_LW, OP_SW: begin
              alu_q   <= addr_sum;
              state_q <= (addr_sum[1:0] != 2'b00) ? S_HALT : S_MEM;
            end
            OP_BEQ: begin
              if (a_q == b_q) pc_q <= alu_q[ADDR_W-1:0];
              state_q <= S_FETCH;
            end
            default: begin
              pc_q    <= jump_tgt[ADDR_W-1:0];
              state_q <= S_FETCH;
            end
          endcase
        end
        S_MEM: if (mem_ready) begin
          if (opcode == OP_LW) begin
            mdr_q   <= mem_rdata;
            state_q <= S_WB;
          end else begin
            state_q <= S_FETCH;
          end
        end
        S_WB: begin
          if (wb_idx != 5'd0) rf_q[wb_idx] <= wb_dat;
          state_q <= S_FETCH;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

`ifdef MCP_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (retire) instret_count <= instret_count + 32'd1;
    end
  end
`endif

endmodule
